// File: rtl/bus_sequencer.sv
// Load/store sequencer: places byte/half/word core accesses onto NB memory byte lanes.
// Lane-crossing accesses are split into two beats or trapped, and each beat has an ack timeout.
module bus_sequencer #(
  parameter int DATA_W          = 16,
  parameter int ADDR_W          = 16,
  parameter int SPLIT_UNALIGNED = 1,
  parameter int TIMEOUT         = 15
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req,
  input  logic                wr,
  input  logic [1:0]          size,
  input  logic                sign_extend,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic                stall,
  output logic                done,
  output logic [DATA_W-1:0]   rdata,
  output logic                exc,
  output logic [1:0]          exc_code,
  output logic                mem_req,
  output logic                mem_wr,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack
);
  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} state_t;
  state_t state, state_nxt;

  function automatic logic [DATA_W-1:0] lane_mask(input logic [NB-1:0] be);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int i = 0; i < NB; i++) m[i*8 +: 8] = {8{be[i]}};
    return m;
  endfunction

  function automatic logic [DATA_W-1:0] rotl_bytes(input logic [DATA_W-1:0] w, input logic [OFF_W-1:0] o);
    logic [2*DATA_W-1:0] t;
    t = {w, w} << {o, 3'b000};
    return t[2*DATA_W-1:DATA_W];
  endfunction

  function automatic logic [DATA_W-1:0] rotr_bytes(input logic [DATA_W-1:0] w, input logic [OFF_W-1:0] o);
    logic [2*DATA_W-1:0] t;
    t = {w, w} >> {o, 3'b000};
    return t[DATA_W-1:0];
  endfunction

  logic [OFF_W-1:0]  off_in, off_q;
  logic [1:0]        size_q;
  logic              wr_q, sext_q;
  logic [ADDR_W-1:0] base_q;
  logic [DATA_W-1:0] wdata_q, data_q, rdata_q;
  logic [NB-1:0]     be0_q, be1_q;
  logic [CNT_W-1:0]  wait_cnt;
  logic              exc_q;
  logic [1:0]        exc_code_q;

  logic              size_ok, crosses, trap, expire, last_beat;
  logic [2*NB-1:0]   lanes, be_span;
  logic [DATA_W-1:0] collected, rotated, ext_mask, msb_sel, rd_result;
  logic [DATA_W:0]   one_sh;

  // Request decode: the access footprint spans two lane groups; the upper group is beat 1.
  assign off_in  = addr[OFF_W-1:0];
  assign size_ok = (size == 2'd0) || (size == 2'd1) || (size == 2'd2 && NB == 4);
  always_comb begin
    case (size)
      2'd0:    lanes = (2*NB)'(1);
      2'd1:    lanes = (2*NB)'(3);
      default: lanes = (2*NB)'(15);
    endcase
  end
  assign be_span = lanes << off_in;
  assign crosses = |be_span[2*NB-1:NB];
  assign trap    = !size_ok || (crosses && SPLIT_UNALIGNED == 0);

  assign expire    = (TIMEOUT > 0) && (wait_cnt == CNT_W'(TIMEOUT - 1));
  assign last_beat = mem_ack && (state == BEAT1 || be1_q == '0);

  // Read assembly: merge this beat's lanes, undo the lane rotation, then extend.
  assign collected = data_q | (mem_rdata & lane_mask(state == BEAT1 ? be1_q : be0_q));
  assign rotated   = rotr_bytes(collected, off_q);
  assign one_sh    = (DATA_W+1)'(1) << (6'd8 << size_q);
  assign ext_mask  = one_sh[DATA_W-1:0] - DATA_W'(1);
  assign msb_sel   = one_sh[DATA_W:1];
  assign rd_result = (rotated & ext_mask) | ((sext_q && |(rotated & msb_sel)) ? ~ext_mask : '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_be    = '0;
    mem_wdata = '0;
    case (state)
      IDLE:  if (req) state_nxt = trap ? DONE : BEAT0;
      BEAT0: begin
        if (mem_ack)     state_nxt = (be1_q != '0) ? BEAT1 : DONE;
        else if (expire) state_nxt = DONE;
      end
      BEAT1: if (mem_ack || expire) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (state == BEAT0 || state == BEAT1) begin
      mem_req   = 1'b1;
      mem_wr    = wr_q;
      mem_addr  = (state == BEAT1) ? base_q + ADDR_W'(NB) : base_q;
      mem_be    = (state == BEAT1) ? be1_q : be0_q;
      mem_wdata = wdata_q;
    end
    stall    = reset_n && ((state == IDLE && req) || mem_req);
    done     = (state == DONE);
    exc      = exc_q;
    exc_code = exc_code_q;
    rdata    = rdata_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      off_q      <= '0;
      size_q     <= '0;
      wr_q       <= 1'b0;
      sext_q     <= 1'b0;
      base_q     <= '0;
      wdata_q    <= '0;
      data_q     <= '0;
      rdata_q    <= '0;
      be0_q      <= '0;
      be1_q      <= '0;
      wait_cnt   <= '0;
      exc_q      <= 1'b0;
      exc_code_q <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (req) begin
            off_q   <= off_in;
            size_q  <= size;
            wr_q    <= wr;
            sext_q  <= sign_extend;
            base_q  <= {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            wdata_q <= rotl_bytes(wdata, off_in);
            be0_q   <= be_span[NB-1:0];
            be1_q   <= be_span[2*NB-1:NB];
            data_q  <= '0;
            if (!size_ok) begin
              exc_q      <= 1'b1;
              exc_code_q <= 2'd3;
            end else if (trap) begin
              exc_q      <= 1'b1;
              exc_code_q <= 2'd1;
            end
          end
        end
        BEAT0, BEAT1: begin
          if (mem_ack) begin
            wait_cnt <= '0;
            data_q   <= collected;
            if (last_beat && !wr_q) rdata_q <= rd_result;
          end else if (expire) begin
            wait_cnt   <= '0;
            exc_q      <= 1'b1;
            exc_code_q <= 2'd2;
            if (!wr_q) rdata_q <= '0;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          exc_q      <= 1'b0;
          exc_code_q <= 2'd0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_bus_sequencer.sv
// Bench for bus_sequencer: directed corner cases and randomized accesses checked
// against a byte-address reference model.
module tb_bus_sequencer;
  localparam int TO = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        req = 1'b0, req2 = 1'b0, wr = 1'b0, sign_extend = 1'b0;
  logic [1:0]  size = 2'd0;
  logic [15:0] addr = '0, wdata = '0, mem_rdata = '0;
  logic        mem_ack = 1'b0, mem_ack2 = 1'b1;

  logic        stall, done, exc, mem_req, mem_wr;
  logic [1:0]  exc_code, mem_be;
  logic [15:0] rdata, mem_addr, mem_wdata;
  logic        stall2, done2, exc2, mem_req2, mem_wr2;
  logic [1:0]  exc_code2, mem_be2;
  logic [15:0] rdata2, mem_addr2, mem_wdata2;

  int          tests = 0;
  int          fails = 0;
  logic [15:0] exp_rdata = '0;

  always #5 clk = ~clk;

  bus_sequencer #(.DATA_W(16), .ADDR_W(16), .SPLIT_UNALIGNED(1), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .wr(wr), .size(size), .sign_extend(sign_extend),
    .addr(addr), .wdata(wdata), .stall(stall), .done(done), .rdata(rdata), .exc(exc),
    .exc_code(exc_code), .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack));

  bus_sequencer #(.DATA_W(16), .ADDR_W(16), .SPLIT_UNALIGNED(0), .TIMEOUT(15)) dut2 (
    .clk(clk), .reset_n(reset_n), .req(req2), .wr(wr), .size(size), .sign_extend(sign_extend),
    .addr(addr), .wdata(wdata), .stall(stall2), .done(done2), .rdata(rdata2), .exc(exc2),
    .exc_code(exc_code2), .mem_req(mem_req2), .mem_wr(mem_wr2), .mem_addr(mem_addr2),
    .mem_be(mem_be2), .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata), .mem_ack(mem_ack2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"}, 32'(stall), 0);     chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_rdata"}, 32'(rdata), 0);     chk({tag, "_exc"}, 32'(exc), 0);
    chk({tag, "_code"}, 32'(exc_code), 0);   chk({tag, "_mreq"}, 32'(mem_req), 0);
    chk({tag, "_mwr"}, 32'(mem_wr), 0);      chk({tag, "_maddr"}, 32'(mem_addr), 0);
    chk({tag, "_mbe"}, 32'(mem_be), 0);      chk({tag, "_mwdata"}, 32'(mem_wdata), 0);
    chk({tag, "_d2_all"}, {stall2, done2, exc2, mem_req2, mem_wr2, exc_code2, mem_be2} , 0);
    chk({tag, "_d2_data"}, {rdata2, mem_addr2 | mem_wdata2}, 0);
  endtask

  // One access on dut: the model works per byte address (addr+i), deciding which beat and
  // lane carries each byte, then drives/checks the bus cycle by cycle.
  task automatic access(input logic w, input logic [1:0] sz, input logic se,
                        input logic [15:0] a, input logic [15:0] wd,
                        input logic [15:0] rd0, input logic [15:0] rd1,
                        input int wt0, input int wt1);
    logic [15:0] ba, aw0, res, exp_wd;
    logic [1:0]  be [2];
    logic [15:0] rd [2];
    int          bytes, off, nbeats, b, lane, wt;
    logic        tmo;
    bytes = 1 << sz;
    off   = int'(a[0]);
    be[0] = '0; be[1] = '0; res = '0; tmo = 1'b0;
    rd[0] = rd0; rd[1] = rd1;
    aw0   = a & 16'hFFFE;
    if (sz < 2) begin
      for (int i = 0; i < bytes; i++) begin
        ba   = a + 16'(i);
        b    = ((ba & 16'hFFFE) != aw0) ? 1 : 0;
        lane = int'(ba[0]);
        be[b][lane] = 1'b1;
        res[8*i +: 8] = rd[b][8*lane +: 8];
      end
    end
    if (se && sz == 2'd0 && res[7]) res[15:8] = 8'hFF;
    for (int l = 0; l < 2; l++) exp_wd[8*l +: 8] = wd[8*((l - off + 2) % 2) +: 8];
    nbeats = (be[1] != 2'b00) ? 2 : 1;

    mem_ack = 1'($urandom_range(0, 1));
    mem_rdata = 16'($urandom);
    @(negedge clk);
    chk("idle_done", 32'(done), 0);
    chk("idle_stall", 32'(stall), 0);
    chk("idle_exc", 32'(exc), 0);
    chk("rdata_hold", 32'(rdata), 32'(exp_rdata));
    req = 1'b1; wr = w; size = sz; sign_extend = se; addr = a; wdata = wd;
    #1;
    chk("req_stall", 32'(stall), 1);
    chk("req_no_mreq", 32'(mem_req), 0);
    @(posedge clk); #1;
    req = 1'b0; wr = 1'($urandom); size = 2'($urandom); sign_extend = 1'($urandom);
    addr = 16'($urandom); wdata = 16'($urandom);

    if (sz >= 2) begin
      @(negedge clk);
      chk("trap_done", 32'(done), 1);
      chk("trap_exc", 32'(exc), 1);
      chk("trap_code", 32'(exc_code), 3);
      chk("trap_mreq", 32'(mem_req), 0);
      chk("trap_stall", 32'(stall), 0);
      chk("trap_rdata", 32'(rdata), 32'(exp_rdata));
      @(posedge clk); #1;
      return;
    end

    for (int bt = 0; bt < nbeats && !tmo; bt++) begin
      wt = (bt == 0) ? wt0 : wt1;
      for (int c = 0; c <= TO; c++) begin
        mem_ack = (c == wt);
        mem_rdata = (c == wt) ? rd[bt] : 16'($urandom);
        @(negedge clk);
        chk("beat_mreq", 32'(mem_req), 1);
        chk("beat_addr", 32'(mem_addr), (bt == 0) ? 32'(aw0) : 32'(16'(aw0 + 16'd2)));
        chk("beat_be", 32'(mem_be), 32'(be[bt]));
        chk("beat_wr", 32'(mem_wr), 32'(w));
        chk("beat_wdata", 32'(mem_wdata), 32'(exp_wd));
        chk("beat_stall", 32'(stall), 1);
        chk("beat_done", 32'(done), 0);
        @(posedge clk); #1;
        mem_ack = 1'b0;
        if (c == wt) break;
        if (c == TO - 1) begin
          tmo = 1'b1;
          break;
        end
      end
    end
    if (!w) exp_rdata = tmo ? 16'h0000 : res;
    mem_ack = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk("done_pulse", 32'(done), 1);
    chk("done_exc", 32'(exc), 32'(tmo));
    chk("done_code", 32'(exc_code), tmo ? 2 : 0);
    chk("done_mreq", 32'(mem_req), 0);
    chk("done_stall", 32'(stall), 0);
    chk("done_rdata", 32'(rdata), 32'(exp_rdata));
    @(posedge clk); #1;
    mem_ack = 1'b0;
  endtask

  initial begin
    logic        w;
    logic [1:0]  sz;
    logic [15:0] a;
    int          w0, w1;

    #2 reset_n = 1'b0; req = 1'b1;
    #2 chk_all_zero("reset");
    req = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Byte read, sign extension from lane 1.
    access(1'b0, 2'd0, 1'b1, 16'h1001, 16'h0000, 16'h8034, 16'h0000, 0, 0);
    chk("byte_sext_value", 32'(rdata), 32'h0000FF80);
    // Split half write with lane-rotated data.
    access(1'b1, 2'd1, 1'b0, 16'h2003, 16'hABCD, 16'h0000, 16'h0000, 0, 0);
    // Split half read wrapping the address space.
    access(1'b0, 2'd1, 1'b0, 16'hFFFF, 16'h0000, 16'h1200, 16'h0034, 0, 0);
    chk("wrap_read_value", 32'(rdata), 32'h00003412);
    // Wait states on both beats, aligned and zero-extended reads.
    access(1'b0, 2'd1, 1'b1, 16'h0101, 16'h0000, 16'h8180, 16'h0000, 2, 0);
    access(1'b0, 2'd0, 1'b0, 16'h0200, 16'h0000, 16'h11F0, 16'h0000, 1, 0);
    access(1'b0, 2'd1, 1'b1, 16'h0301, 16'h0000, 16'h9A00, 16'h00BC, 1, 2);
    // Timeouts on beat 0 and beat 1.
    access(1'b0, 2'd0, 1'b0, 16'h0040, 16'h0000, 16'h0000, 16'h0000, 5, 0);
    chk("timeout_rdata_zero", 32'(rdata), 0);
    access(1'b0, 2'd1, 1'b0, 16'h0101, 16'h0000, 16'h5500, 16'h0000, 0, 0);
    access(1'b0, 2'd1, 1'b0, 16'h0005, 16'h0000, 16'hAA00, 16'h0000, 0, TO);
    // Illegal sizes on a 16-bit bus.
    access(1'b0, 2'd2, 1'b0, 16'h0010, 16'h0000, 16'h0000, 16'h0000, 0, 0);
    access(1'b1, 2'd3, 1'b0, 16'h0011, 16'h1234, 16'h0000, 16'h0000, 0, 0);

    // Trapping instance: misaligned half, then illegal size taking priority.
    for (int k = 0; k < 2; k++) begin
      addr = 16'h0011; size = (k == 0) ? 2'd1 : 2'd2; wr = 1'b0; req2 = 1'b1;
      @(negedge clk);
      chk("trap2_stall", 32'(stall2), 1);
      chk("trap2_mreq_t", 32'(mem_req2), 0);
      @(posedge clk); #1;
      req2 = 1'b0;
      @(negedge clk);
      chk("trap2_done", 32'(done2), 1);
      chk("trap2_exc", 32'(exc2), 1);
      chk("trap2_code", 32'(exc_code2), (k == 0) ? 1 : 3);
      chk("trap2_mreq", 32'(mem_req2), 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("trap2_after_done", 32'(done2), 0);
      chk("trap2_after_exc", 32'({exc2, exc_code2}), 0);
      @(posedge clk); #1;
    end

    // Reset during beat 1 of a split read.
    req = 1'b1; wr = 1'b0; size = 2'd1; sign_extend = 1'b0; addr = 16'h0003; mem_ack = 1'b0;
    @(posedge clk); #1;
    req = 1'b0; mem_ack = 1'b1; mem_rdata = 16'h5500;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("rst_pre_mreq", 32'(mem_req), 1);
    chk("rst_pre_addr", 32'(mem_addr), 32'h0004);
    reset_n = 1'b0; req = 1'b1;
    #1 chk_all_zero("midreset");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midreset_no_done", 32'(done), 0);
    end
    req = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    exp_rdata = '0;
    access(1'b0, 2'd0, 1'b0, 16'h0007, 16'h0000, 16'h9900, 16'h0000, 0, 0);
    chk("post_reset_value", 32'(rdata), 32'h00000099);

    for (int n = 0; n < 80; n++) begin
      w  = 1'($urandom);
      sz = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
      a  = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      w0 = $urandom_range(0, 2);
      w1 = $urandom_range(0, 2);
      if (!w && $urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 1) == 0) w0 = TO;
        else w1 = TO;
      end
      access(w, sz, 1'($urandom), a, 16'($urandom), 16'($urandom), 16'($urandom), w0, w1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t, limit 200000", $time);
    $fatal(1, "bench timed out");
  end
endmodule
